// File: rtl/mantissa_denormalizer_pkg.sv
// Shared numeric definitions for the AdaIN fixed-point path: default widths,
// index-width helper and the payload carried between denormaliser stages.
package adaIN_num_pkg;

    function automatic int unsigned idx_width(input int unsigned w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

    localparam int unsigned WIDTH_DEF  = 48;
    localparam int unsigned MANT_W_DEF = 16;
    localparam int unsigned IDX_W_DEF  = idx_width(WIDTH_DEF);
    localparam int unsigned SH_W       = WIDTH_DEF + MANT_W_DEF;

    // data holds the full {WIDTH zeros, mantissa} field as it is shifted up
    typedef struct packed {
        logic                 nz;
        logic                 ovf;
        logic [IDX_W_DEF-1:0] idx;
        logic [SH_W-1:0]      data;
    } denorm_beat_t;

endpackage

// File: rtl/mantissa_denormalizer_if.sv
// Valid/ready bus of the mantissa denormaliser: input beat plus result channel.
interface mantissa_denormalizer_if
    import adaIN_num_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned MANT_W = MANT_W_DEF,
    parameter int unsigned IDX_W  = idx_width(WIDTH)
);
    logic              in_valid;
    logic              in_ready;
    logic              in_nz;
    logic [IDX_W-1:0]  in_idx;
    logic [MANT_W-1:0] in_mant;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_ovf;

    modport master (
        output in_valid, in_nz, in_idx, in_mant, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_nz, in_idx, in_mant, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/mantissa_denormalizer_denorm_shift_stage.sv
// One registered log-shifter pipeline stage: shifts the payload left by
// idx[SHIFT_LSB +: SHIFT_BITS] * 2**GRAN_LOG2 and holds it under back-pressure.
module denorm_shift_stage
    import adaIN_num_pkg::*;
#(
    parameter int unsigned SHIFT_LSB  = 0,
    parameter int unsigned SHIFT_BITS = 3,
    parameter int unsigned GRAN_LOG2  = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  denorm_beat_t in_beat,
    output logic         out_valid,
    input  logic         out_ready,
    output denorm_beat_t out_beat
);
    logic                  valid_q, valid_d;
    denorm_beat_t          beat_q, beat_d;
    logic [SHIFT_BITS-1:0] sel;
    logic [31:0]           shamt;

    // Loads when empty or when the held beat leaves this cycle
    assign in_ready = !valid_q || out_ready;

    always_comb begin
        sel     = in_beat.idx[SHIFT_LSB +: SHIFT_BITS];
        shamt   = 32'(sel) << GRAN_LOG2;
        valid_d = valid_q;
        beat_d  = beat_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                beat_d      = in_beat;
                beat_d.data = in_beat.data << shamt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

    assign out_valid = valid_q;
    assign out_beat  = beat_q;
endmodule

// File: rtl/mantissa_denormalizer.sv
// 3-stage inverse of the leading-one encoder: places the mantissa MSB at bit in_idx.
// Define DENORM_ROUND_EN to round half-up on truncated bits instead of truncating.
module mantissa_denormalizer
    import adaIN_num_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned MANT_W = MANT_W_DEF,
    parameter int unsigned IDX_W  = idx_width(WIDTH)
) (
    input logic                   clk,
    input logic                   rst_n,
    mantissa_denormalizer_if.slave bus
);
    logic         s1_valid_q, s1_valid_d;
    denorm_beat_t s1_beat_q, s1_beat_d;
    logic         s1_ready;
    logic         s2_ready, s2_valid;
    denorm_beat_t s2_beat;
    logic         s3_ready, s3_valid;
    denorm_beat_t s3_beat;
    logic [WIDTH-1:0] field;
    logic             unused_bits;

    assign s1_ready     = !s1_valid_q || s2_ready;
    assign bus.in_ready = s1_ready;

    // S1: capture the beat and decode zero / overflow up front
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_beat_d  = s1_beat_q;
        if (s1_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_beat_d.nz   = bus.in_nz;
                s1_beat_d.ovf  = bus.in_nz && (32'(bus.in_idx) >= WIDTH);
                s1_beat_d.idx  = bus.in_idx;
                s1_beat_d.data = bus.in_nz ? SH_W'(bus.in_mant) : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_beat_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_beat_q  <= s1_beat_d;
        end
    end

    denorm_shift_stage #(
        .SHIFT_LSB  (3),
        .SHIFT_BITS (IDX_W - 3),
        .GRAN_LOG2  (3)
    ) u_s2_coarse (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid_q),
        .in_ready  (s2_ready),
        .in_beat   (s1_beat_q),
        .out_valid (s2_valid),
        .out_ready (s3_ready),
        .out_beat  (s2_beat)
    );

    denorm_shift_stage #(
        .SHIFT_LSB  (0),
        .SHIFT_BITS (3),
        .GRAN_LOG2  (0)
    ) u_s3_fine (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s2_valid),
        .in_ready  (s3_ready),
        .in_beat   (s2_beat),
        .out_valid (s3_valid),
        .out_ready (bus.out_ready),
        .out_beat  (s3_beat)
    );

    // S3 output side: field extract, optional rounding, saturate / zero
    always_comb begin
        field = s3_beat.data[WIDTH+MANT_W-2 : MANT_W-1];
`ifdef DENORM_ROUND_EN
        if (32'(s3_beat.idx) < MANT_W - 1)
            field = field + WIDTH'(s3_beat.data[MANT_W-2]);
`endif
        bus.out_data = '0;
        bus.out_ovf  = 1'b0;
        if (s3_beat.nz) begin
            if (s3_beat.ovf) begin
                bus.out_data = '1;
                bus.out_ovf  = 1'b1;
            end else begin
                bus.out_data = field;
            end
        end
    end

    assign bus.out_valid = s3_valid;
    assign unused_bits   = ^{s3_beat.data[SH_W-1], s3_beat.data[MANT_W-2:0], s3_beat.idx};
endmodule
